// File: rtl/bus_req_port_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus request port: FSM state encoding, the default
// wait timeout, the access-control width, the captured-request record and a
// helper that sizes the wait counter for a given timeout.
// No ports (package).
// -----------------------------------------------------------------------------
package bus_pkg;

   localparam int TIMEOUT_DEF = 255;
   localparam int CTRL_W      = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Request fields captured from the core when a request is accepted.
   typedef struct packed {
      logic              we;
      logic [31:0]       addr;
      logic [31:0]       wdata;
      logic [CTRL_W-1:0] ctrl;
   } hold_t;

   // Bits needed for a counter that must be able to hold the value t.
   function automatic int cnt_width(input int t);
      return (t < 2) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/bus_req_port_if.sv
// -----------------------------------------------------------------------------
// Interfaces for the bus request port.
//
// bus_req_port_core_if : core-facing side.
//    master  = the core (drives core_req/we/addr/wdata/ctrl)
//    slave   = the port (drives core_busy/done/rdata and err)
//
// bus_req_port_bus_if  : arbiter/bus-facing side.
//    master  = the port (drives arb_req and the bus_* request)
//    slave   = the arbiter (drives arb_gnt, bus_busy, bus_odata)
// -----------------------------------------------------------------------------
interface bus_req_port_core_if;

   logic                      core_req;
   logic                      core_we;
   logic [31:0]               core_addr;
   logic [31:0]               core_wdata;
   logic [bus_pkg::CTRL_W-1:0] core_ctrl;
   logic                      core_busy;
   logic                      core_done;
   logic [31:0]               core_rdata;
   logic                      err;

   modport master (
      output core_req, core_we, core_addr, core_wdata, core_ctrl,
      input  core_busy, core_done, core_rdata, err
   );

   modport slave (
      input  core_req, core_we, core_addr, core_wdata, core_ctrl,
      output core_busy, core_done, core_rdata, err
   );

endinterface

interface bus_req_port_bus_if;

   logic                      arb_req;
   logic                      arb_gnt;
   logic [31:0]               bus_addr;
   logic [31:0]               bus_wdata;
   logic [bus_pkg::CTRL_W-1:0] bus_ctrl;
   logic                      bus_we_t;
   logic                      bus_le;
   logic                      bus_busy;
   logic [31:0]               bus_odata;

   modport master (
      output arb_req, bus_addr, bus_wdata, bus_ctrl, bus_we_t, bus_le,
      input  arb_gnt, bus_busy, bus_odata
   );

   modport slave (
      input  arb_req, bus_addr, bus_wdata, bus_ctrl, bus_we_t, bus_le,
      output arb_gnt, bus_busy, bus_odata
   );

endinterface

// File: rtl/bus_req_port_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Saturating up-counter used to bound the bus wait phase.
//
// Ports:
//    i_clk      clock (rising edge)
//    i_rst      synchronous active-high reset, clears the count
//    i_clr      clear the count to 0 (has priority over i_en)
//    i_en       increment the count, stopping at TIMEOUT
//    o_count    current count
//    o_expired  high while the count equals TIMEOUT
// -----------------------------------------------------------------------------
module wait_timer #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count,
   output logic             o_expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != LIMIT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count   = r_count;
   assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/bus_req_port.sv
// -----------------------------------------------------------------------------
// bus_req_port
// Converts a single core access into an arbitrated bus request:
// IDLE -> REQ (ask arbiter) -> ISSUE (one-cycle strobe) -> WAIT (bus busy,
// bounded by TIMEOUT) -> DONE (one-cycle completion) -> IDLE.
// A timeout completes the access with ERR_DATA and sets a sticky err flag.
//
// Ports:
//    i_clk   clock (rising edge)
//    i_rst   synchronous active-high reset
//    core    bus_req_port_core_if.slave : core request in, busy/done/rdata/err out
//    bus     bus_req_port_bus_if.master : arb_req and bus request out,
//            arb_gnt/bus_busy/bus_odata in
// -----------------------------------------------------------------------------
module bus_req_port
   import bus_pkg::*;
#(
   parameter int          TIMEOUT  = TIMEOUT_DEF,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   bus_req_port_core_if.slave   core,
   bus_req_port_bus_if.master   bus
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   state_e           r_state;
   state_e           w_next;
   hold_t            r_hold;
   logic [31:0]      r_rdata;
   logic             r_err;

   logic             w_capture;
   logic             w_rdata_ld;
   logic [31:0]      w_rdata_d;
   logic             w_set_err;
   logic             w_tmr_clr;
   logic             w_tmr_en;
   logic             w_tmr_expired;
   logic [CNT_W-1:0] w_count;
   logic             w_drive;

   wait_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wait_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_count   (w_count),
      .o_expired (w_tmr_expired)
   );

   // State register and datapath registers.
   // NOTE: the holding registers are reset along with the FSM so an aborted
   // transaction leaves no stale address/data on the bus outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_hold <= '{we:    core.core_we,
                        addr:  core.core_addr,
                        wdata: core.core_wdata,
                        ctrl:  core.core_ctrl};
         end
         if (w_rdata_ld) r_rdata <= w_rdata_d;
         if (w_set_err)  r_err   <= 1'b1;
      end
   end

   // Next-state and control decode.
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_next        = r_state;
      w_capture     = 1'b0;
      w_rdata_ld    = 1'b0;
      w_rdata_d     = r_rdata;
      w_set_err     = 1'b0;
      w_tmr_clr     = 1'b0;
      w_tmr_en      = 1'b0;
      w_drive       = 1'b0;
      bus.arb_req   = 1'b0;
      bus.bus_we_t  = 1'b0;
      bus.bus_le    = 1'b0;
      core.core_done = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (core.core_req) begin
               w_capture = 1'b1;
               w_next    = ST_REQ;
            end
         end
         ST_REQ: begin
            bus.arb_req = 1'b1;
            if (bus.arb_gnt) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            bus.arb_req  = 1'b1;
            w_drive      = 1'b1;
            bus.bus_we_t = r_hold.we;
            bus.bus_le   = !r_hold.we;
            w_tmr_clr    = 1'b1;
            w_next       = ST_WAIT;
         end
         ST_WAIT: begin
            // arb_gnt is not consulted here: once issued, only bus_busy and
            // the timer decide completion, so a dropped grant never reissues.
            bus.arb_req = 1'b1;
            w_drive     = 1'b1;
            w_tmr_en    = 1'b1;
            // The bus needs at least one WAIT cycle before busy is trusted.
            if (!bus.bus_busy && (w_count != '0)) begin
               w_next = ST_DONE;
               if (!r_hold.we) begin
                  w_rdata_ld = 1'b1;
                  w_rdata_d  = bus.bus_odata;
               end
            end else if (w_tmr_expired) begin
               w_set_err  = 1'b1;
               w_rdata_ld = 1'b1;
               w_rdata_d  = ERR_DATA;
               w_next     = ST_DONE;
            end
         end
         ST_DONE: begin
            w_drive        = 1'b1;
            core.core_done = 1'b1;
            w_next         = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign core.core_busy  = (r_state != ST_IDLE);
   assign core.core_rdata = r_rdata;
   assign core.err        = r_err;

   assign bus.bus_addr  = w_drive ? r_hold.addr  : '0;
   assign bus.bus_wdata = w_drive ? r_hold.wdata : '0;
   assign bus.bus_ctrl  = w_drive ? r_hold.ctrl  : '0;

endmodule

// File: tb/tb_bus_req_port.sv
// -----------------------------------------------------------------------------
// tb_bus_req_port
// Directed bench for bus_req_port (TIMEOUT=4). Stimulus pushes the expected
// completion (rdata, err) into a scoreboard queue; a monitor on the falling
// edge pops and compares on every core_done pulse. Cycle-exact protocol
// checks are made inline, 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_bus_req_port;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   bus_req_port_core_if u_core ();
   bus_req_port_bus_if  u_bus ();

   bus_req_port #(
      .TIMEOUT  (4),
      .ERR_DATA (32'hFFFF_FFFF)
   ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .core  (u_core),
      .bus   (u_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] ctrl);
      u_core.core_req   = req;
      u_core.core_we    = we;
      u_core.core_addr  = addr;
      u_core.core_wdata = wdata;
      u_core.core_ctrl  = ctrl;
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (u_core.core_done === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected_done: got done=1 expected no completion at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               check("sb_rdata", u_core.core_rdata, e.rdata);
               check("sb_err", 32'(u_core.err), 32'(e.err));
            end
         end
      end
   end

   // Global watchdog.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cnt;
      int first_done;
      int second_done;

      rst = 1'b1;
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      u_bus.arb_gnt   = 1'b0;
      u_bus.bus_busy  = 1'b0;
      u_bus.bus_odata = 32'h0;
      step(3);

      // Reset state.
      check("rst_busy",    32'(u_core.core_busy), 32'd0);
      check("rst_done",    32'(u_core.core_done), 32'd0);
      check("rst_arb_req", 32'(u_bus.arb_req),    32'd0);
      check("rst_rdata",   u_core.core_rdata,     32'h0);
      check("rst_err",     32'(u_core.err),       32'd0);
      check("rst_addr",    u_bus.bus_addr,        32'h0);
      rst = 1'b0;
      step();

      // ---- Read, zero-wait arbiter and bus: done at cycle 5 ----
      u_bus.arb_gnt   = 1'b1;
      u_bus.bus_busy  = 1'b0;
      u_bus.bus_odata = 32'hDEAD_BEEF;
      sb_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      set_req(1'b1, 1'b0, 32'h0000_0100, 32'h5555_AAAA, 3'b010);
      step();                                            // cycle 1: REQ
      u_core.core_req = 1'b0;
      check("rd_c1_busy",    32'(u_core.core_busy), 32'd1);
      check("rd_c1_arb_req", 32'(u_bus.arb_req),    32'd1);
      check("rd_c1_le",      32'(u_bus.bus_le),     32'd0);
      check("rd_c1_addr",    u_bus.bus_addr,        32'h0);
      step();                                            // cycle 2: ISSUE
      check("rd_c2_le",   32'(u_bus.bus_le),   32'd1);
      check("rd_c2_we_t", 32'(u_bus.bus_we_t), 32'd0);
      check("rd_c2_addr", u_bus.bus_addr,      32'h0000_0100);
      check("rd_c2_ctrl", 32'(u_bus.bus_ctrl), 32'd2);
      step();                                            // cycle 3: WAIT
      check("rd_c3_le",      32'(u_bus.bus_le),     32'd0);
      check("rd_c3_arb_req", 32'(u_bus.arb_req),    32'd1);
      step();                                            // cycle 4: WAIT
      check("rd_c4_done", 32'(u_core.core_done), 32'd0);
      step();                                            // cycle 5: DONE
      check("rd_c5_done",    32'(u_core.core_done), 32'd1);
      check("rd_c5_arb_req", 32'(u_bus.arb_req),    32'd0);
      check("rd_c5_addr",    u_bus.bus_addr,        32'h0000_0100);
      step();                                            // cycle 6: IDLE
      check("rd_c6_done",  32'(u_core.core_done), 32'd0);
      check("rd_c6_busy",  32'(u_core.core_busy), 32'd0);
      check("rd_c6_rdata", u_core.core_rdata,     32'hDEAD_BEEF);
      check("rd_c6_addr",  u_bus.bus_addr,        32'h0);

      // ---- Write, grant delayed 7 cycles, grant dropped in WAIT ----
      u_bus.arb_gnt   = 1'b0;
      u_bus.bus_odata = 32'hAAAA_5555;
      sb_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      set_req(1'b1, 1'b1, 32'h8000_0010, 32'h1234_5678, 3'b101);
      step();                                            // REQ
      u_core.core_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check("wr_req_arb_req", 32'(u_bus.arb_req),  32'd1);
         check("wr_req_we_t",    32'(u_bus.bus_we_t), 32'd0);
         step();
      end
      u_bus.arb_gnt = 1'b1;
      step();                                            // ISSUE
      check("wr_we_t",  32'(u_bus.bus_we_t), 32'd1);
      check("wr_le",    32'(u_bus.bus_le),   32'd0);
      check("wr_addr",  u_bus.bus_addr,      32'h8000_0010);
      check("wr_wdata", u_bus.bus_wdata,     32'h1234_5678);
      check("wr_ctrl",  32'(u_bus.bus_ctrl), 32'd5);
      u_bus.arb_gnt = 1'b0;
      step();                                            // WAIT, count 0
      check("wr_wait_we_t",    32'(u_bus.bus_we_t), 32'd0);
      check("wr_wait_arb_req", 32'(u_bus.arb_req),  32'd1);
      check("wr_wait_wdata",   u_bus.bus_wdata,     32'h1234_5678);
      step();                                            // WAIT, count 1
      step();                                            // DONE
      check("wr_done",  32'(u_core.core_done), 32'd1);
      check("wr_rdata", u_core.core_rdata,     32'hDEAD_BEEF);
      step();                                            // IDLE

      // ---- Read timeout with TIMEOUT=4 ----
      u_bus.arb_gnt  = 1'b1;
      u_bus.bus_busy = 1'b1;
      sb_q.push_back('{rdata: 32'hFFFF_FFFF, err: 1'b1});
      set_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b001);
      step();                                            // cycle 1 REQ
      u_core.core_req = 1'b0;
      step(6);                                           // cycle 7 WAIT count 4
      check("to_c7_done", 32'(u_core.core_done), 32'd0);
      check("to_c7_err",  32'(u_core.err),       32'd0);
      step();                                            // cycle 8 DONE
      check("to_c8_done",  32'(u_core.core_done), 32'd1);
      check("to_c8_err",   32'(u_core.err),       32'd1);
      check("to_c8_rdata", u_core.core_rdata,     32'hFFFF_FFFF);
      step();
      check("to_after_done", 32'(u_core.core_done), 32'd0);
      check("to_after_err",  32'(u_core.err),       32'd1);

      // ---- Good read after error; core_req pulses in REQ and WAIT ignored ----
      u_bus.arb_gnt   = 1'b0;
      u_bus.bus_busy  = 1'b1;
      u_bus.bus_odata = 32'h0BAD_F00D;
      sb_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b1});
      set_req(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0033, 3'b001);
      step();                                            // REQ
      set_req(1'b1, 1'b1, 32'h0000_0999, 32'h9999_9999, 3'b111);
      step();                                            // still REQ
      u_core.core_req = 1'b0;
      u_bus.arb_gnt   = 1'b1;
      step();                                            // ISSUE
      check("hold_issue_addr", u_bus.bus_addr,      32'h0000_0300);
      check("hold_issue_le",   32'(u_bus.bus_le),   32'd1);
      check("hold_issue_we_t", 32'(u_bus.bus_we_t), 32'd0);
      step();                                            // WAIT count 0
      set_req(1'b1, 1'b1, 32'h0000_0999, 32'h9999_9999, 3'b111);
      step();                                            // WAIT count 1
      u_core.core_req = 1'b0;
      check("hold_wait_addr",  u_bus.bus_addr,      32'h0000_0300);
      check("hold_wait_wdata", u_bus.bus_wdata,     32'h0000_0033);
      check("hold_wait_ctrl",  32'(u_bus.bus_ctrl), 32'd1);
      u_bus.bus_busy = 1'b0;
      step();                                            // DONE
      check("good_done",  32'(u_core.core_done), 32'd1);
      check("good_rdata", u_core.core_rdata,     32'h0BAD_F00D);
      check("good_err",   32'(u_core.err),       32'd1);
      step();                                            // IDLE, no capture
      check("good_idle_busy", 32'(u_core.core_busy), 32'd0);
      step();
      check("good_idle_busy2", 32'(u_core.core_busy), 32'd0);

      // ---- Reset asserted in WAIT ----
      u_bus.arb_gnt  = 1'b1;
      u_bus.bus_busy = 1'b1;
      set_req(1'b1, 1'b0, 32'h0000_0400, 32'h0, 3'b011);
      step();                                            // REQ
      u_core.core_req = 1'b0;
      step(2);                                           // WAIT
      check("rw_pre_arb_req", 32'(u_bus.arb_req), 32'd1);
      rst = 1'b1;
      step();
      check("rw_busy",    32'(u_core.core_busy), 32'd0);
      check("rw_arb_req", 32'(u_bus.arb_req),    32'd0);
      check("rw_done",    32'(u_core.core_done), 32'd0);
      check("rw_err",     32'(u_core.err),       32'd0);
      check("rw_rdata",   u_core.core_rdata,     32'h0);
      check("rw_addr",    u_bus.bus_addr,        32'h0);
      rst = 1'b0;
      u_bus.bus_busy = 1'b0;
      step(6);                                           // monitor flags any done
      check("rw_idle_busy", 32'(u_core.core_busy), 32'd0);

      // ---- Back-to-back with core_req held high ----
      u_bus.arb_gnt   = 1'b1;
      u_bus.bus_busy  = 1'b0;
      u_bus.bus_odata = 32'h1111_2222;
      sb_q.push_back('{rdata: 32'h1111_2222, err: 1'b0});
      sb_q.push_back('{rdata: 32'h1111_2222, err: 1'b0});
      set_req(1'b1, 1'b0, 32'h0000_0500, 32'h0, 3'b010);
      done_cnt    = 0;
      first_done  = -1;
      second_done = -1;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 6) check("b2b_c6_idle", 32'(u_core.core_busy), 32'd0);
         if (c == 7) u_core.core_req = 1'b0;
         if (u_core.core_done === 1'b1) begin
            done_cnt++;
            if (first_done < 0) first_done = c;
            else if (second_done < 0) second_done = c;
         end
      end
      check("b2b_done_count", 32'(done_cnt),    32'd2);
      check("b2b_first",      32'(first_done),  32'd5);
      check("b2b_second",     32'(second_done), 32'd11);

      step(3);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_req_port.md
BUS_REQ_PORT -- requirements
Module: bus_req_port

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of WAIT cycles before the request is aborted.
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF, SHALL set the read data returned on a timeout.
REQ-003 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  in  1  SHALL be a synchronous, active-high reset.
REQ-005 core_req  in  1  SHALL be the core request strobe, sampled only in IDLE.
REQ-006 core_we  in  1  SHALL select write (1) or read (0).
REQ-007 core_addr  in  32  SHALL be the physical address.
REQ-008 core_wdata  in  32  SHALL be the write data.
REQ-009 core_ctrl  in  3  SHALL be the access size/control code, passed through unchanged.
REQ-010 core_busy  out  1  SHALL be high while a request is held (any state except IDLE).
REQ-011 core_done  out  1  SHALL be a one-cycle completion pulse.
REQ-012 core_rdata  out  32  SHALL be the read result, valid while core_done is high and held until the next capture.
REQ-013 arb_req  out  1  SHALL request bus ownership from the arbiter.
REQ-014 arb_gnt  in  1  SHALL indicate that this port owns the bus.
REQ-015 bus_addr, bus_wdata  out  32 each; bus_ctrl  out  3; bus_we_t, bus_le  out  1 each  SHALL form the bus-side request.
REQ-016 bus_busy  in  1  and  bus_odata  in  32  SHALL be the arbiter's busy and read-data returns.
REQ-017 err  out  1  SHALL be a sticky timeout flag.

Function
REQ-018 States SHALL be IDLE, REQ, ISSUE, WAIT and DONE.
REQ-019 IDLE: when core_req=1, the port SHALL capture we/addr/wdata/ctrl into holding registers and move to REQ; core_req SHALL be ignored in every other state.
REQ-020 REQ: arb_req SHALL be 1; when arb_gnt=1, the port SHALL move to ISSUE.
REQ-021 ISSUE: the port SHALL drive bus_we_t=we or bus_le=!we for exactly one cycle, then move to WAIT with the wait counter cleared.
REQ-022 bus_addr, bus_wdata and bus_ctrl SHALL be driven from the holding registers from ISSUE through DONE, and SHALL be 0 otherwise.
REQ-023 arb_req SHALL stay 1 from REQ through WAIT, and SHALL be 0 in IDLE and DONE.
REQ-024 WAIT: the counter SHALL increment each cycle, saturating at TIMEOUT; the port SHALL exit to DONE when bus_busy=0 and the counter is at least 1; on a read it SHALL latch bus_odata into core_rdata.
REQ-025 WAIT: if the counter reaches TIMEOUT while bus_busy=1, the port SHALL set err, load core_rdata with ERR_DATA and move to DONE.
REQ-026 DONE: core_done SHALL be 1 for exactly one cycle, then the port SHALL return to IDLE.
REQ-027 A new request SHALL be capturable no earlier than the cycle after DONE.
REQ-028 Minimum latency, with arb_gnt and bus_busy both 0-wait: core_req sampled at cycle 0 SHALL give core_done at cycle 5.
REQ-029 If arb_gnt drops in WAIT, the port SHALL continue waiting on bus_busy without reissuing the request.
REQ-030 Writes SHALL leave core_rdata unchanged.

Reset
REQ-031 While RST=1 at a clock edge, the port SHALL enter IDLE and clear all outputs, holding registers, the counter and err to 0, including when reset arrives mid-transaction.
REQ-032 err SHALL clear only on reset.

Structure
REQ-033 The state encoding, the TIMEOUT default and the ctrl width SHALL live in a shared package (bus_pkg).
REQ-034 The saturating wait counter SHALL be a sub-module named wait_timer (inputs clr and en; outputs count and expired).

Verification
REQ-035 Read, arb_gnt=1, bus_busy=0, bus_odata=32'hDEADBEEF, core_req at cycle 0 -> bus_le=1 at cycle 2, core_done at cycle 5, core_rdata=32'hDEADBEEF.
REQ-036 Write to addr 32'h8000_0010, data 32'h1234_5678, arb_gnt delayed 7 cycles -> bus_we_t one cycle after arb_gnt rises, bus_addr/bus_wdata match, core_rdata unchanged.
REQ-037 bus_busy held at 1 for TIMEOUT=4 -> err=1, core_rdata=32'hFFFF_FFFF, core_done pulses once, err stays 1 through the next good request.
REQ-038 core_req pulsed in REQ and WAIT -> no new capture; holding registers unchanged.
REQ-039 RST asserted in WAIT -> next cycle state IDLE, arb_req=0, core_busy=0, no core_done.
REQ-040 Back-to-back requests with core_req held at 1 -> second capture in the cycle after DONE; two core_done pulses, separated by at least 5 cycles.
